// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 scan sequencer.
// Channel count, code width and FSM state encoding live here.
package mcp3008_pkg;

    localparam int NUM_CH = 8;
    localparam int CODE_W = 10;
    localparam int CH_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WAIT,
        ST_NEXT
    } seq_state_t;

    // Lowest set bit of a channel mask; 0 when the mask is empty.
    function automatic logic [CH_W-1:0] lowest_chan(
        input logic [NUM_CH-1:0] mask
    );
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r = CH_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mcp3008_next_chan.sv
// Priority search for the next enabled channel above ch.
// last is set when ch is the highest enabled channel of the mask.
module mcp3008_next_chan
    import mcp3008_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ch,
    output logic [CH_W-1:0]   next_ch,
    output logic              found,
    output logic              last
);

    // Descending loop: the final hit is the lowest bit above ch.
    always_comb begin
        next_ch = ch;
        found   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(ch))) begin
                next_ch = CH_W'(i);
                found   = 1'b1;
            end
        end
    end

    assign last = !found;

endmodule

// File: rtl/mcp3008_scan_sequencer.sv
// Paces scans over enabled MCP3008 channels and streams tagged results.
// Drives sample/accept of the interface block; holds results under backpressure.
module mcp3008_scan_sequencer
    import mcp3008_pkg::*;
#(
    parameter int PERIOD_W       = 24,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   chan_mask,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clear_status,
    output logic                adc_sample,
    output logic [CH_W-1:0]     adc_channel,
    input  logic                adc_busy,
    input  logic [15:0]         adc_data,
    input  logic                adc_avail,
    output logic                adc_accept,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CH_W-1:0]     res_channel,
    output logic [CODE_W-1:0]   res_data,
    output logic                res_last,
    output logic [15:0]         scan_count,
    output logic                overrun,
    output logic                timeout
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t state;
    seq_state_t state_nx;

    logic [PERIOD_W-1:0] per_cnt;
    logic                tick;
    logic [NUM_CH-1:0]   scan_mask;
    logic [CH_W-1:0]     ch;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                tmo_hit;
    logic                res_free;

    logic                start_scan;
    logic                step;
    logic                scan_done;
    logic                capture;
    logic                tmo_set;
    logic                ovr_set;

    logic [CH_W-1:0]     nxt_ch;
    logic                nxt_found;
    logic                nxt_last;

    logic                unused_data;

    assign unused_data = ^adc_data[15:CODE_W];

    mcp3008_next_chan u_next_chan (
        .mask    (scan_mask),
        .ch      (ch),
        .next_ch (nxt_ch),
        .found   (nxt_found),
        .last    (nxt_last)
    );

    assign tick        = enable && (per_cnt == period);
    assign res_free    = !res_valid || res_ready;
    assign tmo_hit     = (tmo_cnt == TMO_LAST);
    assign ovr_set     = tick && (state != ST_IDLE);
    assign adc_channel = ch;

    // Free-running scan pacing; held at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (!enable || tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PERIOD_W'(1);
        end
    end

    always_comb begin
        state_nx   = state;
        adc_sample = 1'b0;
        adc_accept = 1'b0;
        start_scan = 1'b0;
        step       = 1'b0;
        scan_done  = 1'b0;
        capture    = 1'b0;
        tmo_set    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (tick && (chan_mask != '0)) begin
                    start_scan = 1'b1;
                    state_nx   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                adc_sample = 1'b1;
                if (tmo_hit) begin
                    tmo_set  = 1'b1;
                    state_nx = ST_NEXT;
                end else if (adc_busy || adc_avail) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (adc_avail && res_free) begin
                    adc_accept = 1'b1;
                    capture    = 1'b1;
                    state_nx   = ST_NEXT;
                end else if (tmo_hit) begin
                    tmo_set  = 1'b1;
                    state_nx = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (nxt_found) begin
                    step     = 1'b1;
                    state_nx = ST_SCAN;
                end else begin
                    scan_done = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            scan_mask  <= '0;
            ch         <= '0;
            tmo_cnt    <= '0;
            scan_count <= '0;
        end else begin
            state <= state_nx;
            if (start_scan) begin
                scan_mask <= chan_mask;
                ch        <= lowest_chan(chan_mask);
            end
            if (step) begin
                ch <= nxt_ch;
            end
            // Conversion watchdog restarts for every channel.
            if (start_scan || step) begin
                tmo_cnt <= '0;
            end else if ((state == ST_SCAN) || (state == ST_WAIT)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (scan_done) begin
                scan_count <= scan_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_channel <= '0;
            res_data    <= '0;
            res_last    <= 1'b0;
        end else if (capture) begin
            res_valid   <= 1'b1;
            res_channel <= ch;
            res_data    <= adc_data[CODE_W-1:0];
            res_last    <= nxt_last;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Set events take priority over a coinciding clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_status) begin
                overrun <= 1'b0;
            end
            if (tmo_set) begin
                timeout <= 1'b1;
            end else if (clear_status) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mcp3008_scan_sequencer.sv
// Scoreboard bench: an ADC model pushes expected results, a monitor pops them.
module tb_mcp3008_scan_sequencer;

    typedef struct packed {
        logic [2:0] ch;
        logic [9:0] code;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  chan_mask;
    logic [23:0] period;
    logic        clear_status;
    logic        adc_sample;
    logic [2:0]  adc_channel;
    logic        adc_busy;
    logic [15:0] adc_data;
    logic        adc_avail;
    logic        adc_accept;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_channel;
    logic [9:0]  res_data;
    logic        res_last;
    logic [15:0] scan_count;
    logic        overrun;
    logic        timeout;

    exp_t sb[$];
    int   starts[$];
    int   rise_cyc[8];
    int   n_chk;
    int   n_pass;
    int   cyc;
    int   popped;
    int   hold_err;
    int   acc_seen;
    int   smp_seen;
    int   tmo_rise;
    int   lat;
    int   dead_ch;
    logic [7:0] cur_mask;
    logic [6:0] seq;

    mcp3008_scan_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .chan_mask    (chan_mask),
        .period       (period),
        .clear_status (clear_status),
        .adc_sample   (adc_sample),
        .adc_channel  (adc_channel),
        .adc_busy     (adc_busy),
        .adc_data     (adc_data),
        .adc_avail    (adc_avail),
        .adc_accept   (adc_accept),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_channel  (res_channel),
        .res_data     (res_data),
        .res_last     (res_last),
        .scan_count   (scan_count),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int hi_bit(input logic [7:0] m);
        int r;
        r = -1;
        for (int i = 0; i < 8; i++) if (m[i]) r = i;
        return r;
    endfunction

    function automatic int lo_bit(input logic [7:0] m);
        int r;
        r = -1;
        for (int i = 7; i >= 0; i--) if (m[i]) r = i;
        return r;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_scans(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (scan_count != 16'(n) && k < budget) begin
            cycles(1);
            k++;
        end
        chk(tag, scan_count, n);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        sb.delete();
        starts.delete();
        popped = 0;
        hold_err = 0;
        acc_seen = 0;
        smp_seen = 0;
        tmo_rise = 0;
        dead_ch = -1;
    endtask

    // Conversion model: answers lat cycles after a sample, can play dead.
    initial begin : adc_model
        logic s, a, r, act;
        logic [2:0] c, c_in;
        int cnt;
        exp_t e;
        act = 1'b0;
        cnt = 0;
        c = '0;
        forever begin
            @(posedge clk);
            s = adc_sample;
            a = adc_accept;
            r = rst;
            c_in = adc_channel;
            #1;
            if (r) begin
                act = 1'b0;
                adc_busy = 1'b0;
                adc_avail = 1'b0;
            end else begin
                if (a) adc_avail = 1'b0;
                if (act) begin
                    cnt--;
                    if (cnt == 0) begin
                        act = 1'b0;
                        adc_busy = 1'b0;
                        if (int'(c) != dead_ch) begin
                            adc_avail = 1'b1;
                            adc_data = {6'h2A, c, seq};
                            e.ch = c;
                            e.code = {c, seq};
                            e.last = (int'(c) == hi_bit(cur_mask));
                            sb.push_back(e);
                            seq++;
                        end
                    end
                end else if (s && !adc_avail) begin
                    act = 1'b1;
                    cnt = lat;
                    c = c_in;
                    adc_busy = 1'b1;
                end
            end
        end
    end

    initial begin : monitor
        logic pv, pr, ps, pt, prst, pl;
        logic [2:0] pc;
        logic [9:0] pd;
        exp_t e;
        {pv, pr, ps, pt, prst, pl, pc, pd} = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && !prst) begin
                if (pv && !pr && (!res_valid || res_channel != pc ||
                    res_data != pd || res_last != pl)) hold_err++;
                if (adc_accept) acc_seen++;
                if (adc_sample) smp_seen++;
                if (adc_sample && !ps) begin
                    rise_cyc[adc_channel] = cyc;
                    if (int'(adc_channel) == lo_bit(cur_mask))
                        starts.push_back(cyc);
                end
                if (timeout && !pt) tmo_rise = cyc;
                if (res_valid && res_ready) begin
                    chk("sb_has_entry", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("res", {res_channel, res_data, res_last}, e);
                        popped++;
                    end
                end
            end
            pv = res_valid;
            pr = res_ready;
            ps = adc_sample;
            pt = timeout;
            prst = rst;
            pc = res_channel;
            pd = res_data;
            pl = res_last;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int k, acc0;
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        seq = '0;
        lat = 50;
        dead_ch = -1;
        cur_mask = '0;
        rst = 1'b1;
        enable = 1'b0;
        chan_mask = '0;
        period = '0;
        clear_status = 1'b0;
        res_ready = 1'b1;
        adc_busy = 1'b0;
        adc_avail = 1'b0;
        adc_data = '0;
        cycles(3);
        chk("rst_flags", {adc_sample, adc_accept, res_valid, res_last,
                          overrun, timeout}, 0);
        chk("rst_count", scan_count, 0);
        chk("rst_data", {res_channel, res_data, adc_channel}, 0);

        // Three-channel scan, pacing and last flag
        do_reset();
        cur_mask = 8'h25;
        chan_mask = cur_mask;
        period = 24'd999;
        lat = 50;
        enable = 1'b1;
        wait_scans("t1_scan1", 1, 1500);
        chk("t1_popped", popped, 3);
        chk("t1_sb_empty", sb.size(), 0);
        k = 0;
        while (starts.size() < 2 && k < 1500) begin
            cycles(1);
            k++;
        end
        chk("t1_starts", starts.size(), 2);
        if (starts.size() >= 2) chk("t1_spacing", starts[1] - starts[0], 1000);
        enable = 1'b0;
        wait_scans("t1_scan2", 2, 1000);
        chk("t1_overrun", overrun, 0);
        chk("t1_timeout", timeout, 0);

        // Backpressure on the result stream; enable dropped mid-scan
        do_reset();
        res_ready = 1'b0;
        enable = 1'b1;
        k = 0;
        while (!res_valid && k < 1500) begin
            cycles(1);
            k++;
        end
        chk("t2_first", res_valid, 1);
        enable = 1'b0;
        acc0 = acc_seen;
        hold_err = 0;
        cycles(200);
        chk("t2_accept_held", acc_seen - acc0, 0);
        chk("t2_hold", hold_err, 0);
        chk("t2_pending", sb.size(), 2);
        chk("t2_avail", adc_avail, 1);
        res_ready = 1'b1;
        wait_scans("t2_scan", 1, 500);
        chk("t2_popped", popped, 3);
        chk("t2_sb_empty", sb.size(), 0);

        // Overrun, clear, and set-beats-clear
        do_reset();
        cur_mask = 8'h01;
        chan_mask = cur_mask;
        period = 24'd10;
        lat = 100;
        enable = 1'b1;
        cycles(300);
        chk("t3_overrun", overrun, 1);
        enable = 1'b0;
        cycles(300);
        chk("t3_sticky", overrun, 1);
        clear_status = 1'b1;
        cycles(1);
        clear_status = 1'b0;
        chk("t3_cleared", overrun, 0);
        period = 24'd0;
        enable = 1'b1;
        k = 0;
        while (!adc_busy && k < 100) begin
            cycles(1);
            k++;
        end
        clear_status = 1'b1;
        cycles(1);
        clear_status = 1'b0;
        chk("t3_set_wins", overrun, 1);
        enable = 1'b0;
        cycles(300);
        chk("t3_sb_empty", sb.size(), 0);

        // Dead channel 3 -> timeout, others delivered
        do_reset();
        cur_mask = 8'h0F;
        chan_mask = cur_mask;
        period = 24'd999;
        lat = 50;
        dead_ch = 3;
        enable = 1'b1;
        k = 0;
        while (!adc_sample && k < 1500) begin
            cycles(1);
            k++;
        end
        enable = 1'b0;
        wait_scans("t4_scan", 1, 6000);
        chk("t4_timeout", timeout, 1);
        chk("t4_popped", popped, 3);
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_tmo_delay", tmo_rise - rise_cyc[3], 4096);
        chk("t4_overrun", overrun, 0);
        dead_ch = -1;

        // Empty mask never samples
        do_reset();
        cur_mask = 8'h00;
        chan_mask = cur_mask;
        period = 24'd5;
        enable = 1'b1;
        cycles(200);
        chk("t5_samples", smp_seen, 0);
        chk("t5_count", scan_count, 0);
        enable = 1'b0;

        // Reset while waiting on a conversion
        do_reset();
        cur_mask = 8'h25;
        chan_mask = cur_mask;
        period = 24'd999;
        enable = 1'b1;
        k = 0;
        while (!adc_busy && k < 1500) begin
            cycles(1);
            k++;
        end
        chk("t6_busy", adc_busy, 1);
        rst = 1'b1;
        cycles(1);
        chk("t6_rst_flags", {adc_sample, adc_accept, res_valid, res_last,
                             overrun, timeout, adc_channel, res_channel}, 0);
        chk("t6_rst_data", {scan_count, 6'd0, res_data}, 0);
        rst = 1'b0;
        sb.delete();
        popped = 0;
        wait_scans("t6_scan", 1, 1500);
        chk("t6_popped", popped, 3);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_timeout", timeout, 0);
        enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
